// File: rtl/div32s16s_restoring_seq.sv
// Sequential 32/16 signed divider: radix-2 restoring on operand magnitudes,
// one quotient bit per cycle, fixed 17-cycle latency from transfer to result.
module div32s16s_restoring_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        overflow,
  output logic        div_by_zero,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on any clk edge where valid && ready are
  // both high; the producer holds its data stable until that edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [16:0] r;
  logic [15:0] lo;
  logic [15:0] q;
  logic [15:0] b_mag;
  logic [3:0]  count;
  logic        sign_q, sign_r, dz, pre_ovf;

  logic [31:0] a_abs;
  logic [15:0] b_abs;
  logic [16:0] r_shift;
  logic [17:0] trial;
  logic        q_big;

  assign a_abs   = dividend[31] ? (32'd0 - dividend) : dividend;
  assign b_abs   = divisor[15] ? (16'd0 - divisor) : divisor;
  assign r_shift = {r[15:0], lo[15]};
  assign trial   = {1'b0, r_shift} - {2'b00, b_mag};
  // Negative results may reach magnitude 32768; positive ones only 32767.
  assign q_big   = sign_q ? (q[15] && (q[14:0] != 15'd0)) : q[15];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)        state_nx = CALC;
      CALC:    if (count == 4'd15)  state_nx = FIXUP;
      FIXUP:                        state_nx = DONE;
      DONE:    if (out_ready)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= 17'd0;
      lo          <= 16'd0;
      q           <= 16'd0;
      b_mag       <= 16'd0;
      count       <= 4'd0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      pre_ovf     <= 1'b0;
      quotient    <= 16'd0;
      remainder   <= 16'd0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          r       <= {1'b0, a_abs[31:16]};
          lo      <= a_abs[15:0];
          q       <= 16'd0;
          b_mag   <= b_abs;
          count   <= 4'd0;
          sign_q  <= dividend[31] ^ divisor[15];
          sign_r  <= dividend[31];
          dz      <= (divisor == 16'd0);
          // High half already >= divisor means the quotient needs 17+ bits.
          pre_ovf <= (a_abs[31:16] >= b_abs) && (divisor != 16'd0);
        end
        CALC: begin
          lo    <= {lo[14:0], 1'b0};
          count <= count + 4'd1;
          if (!trial[17]) begin
            r <= trial[16:0];
            q <= {q[14:0], 1'b1};
          end else begin
            r <= r_shift;
            q <= {q[14:0], 1'b0};
          end
        end
        FIXUP: begin
          if (dz) begin
            quotient    <= sign_r ? 16'h8000 : 16'h7FFF;
            remainder   <= 16'd0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (pre_ovf || q_big) begin
            quotient    <= sign_q ? 16'h8000 : 16'h7FFF;
            remainder   <= 16'd0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= sign_q ? (16'd0 - q) : q;
            remainder   <= sign_r ? (16'd0 - r[15:0]) : r[15:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
